// File: rtl/datapath_controller.sv
// Command sequencer producing the per-cycle LEGv8 datapath control word.
// One command at a time over valid/ready; single ops take one EXEC cycle, LOOP takes imm.
module datapath_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [4:0]  cmd_fn,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_rn,
  input  logic [4:0]  cmd_rm,
  input  logic [11:0] cmd_imm,
  input  logic        cmd_cin,
  input  logic        cmd_setf,
  input  logic [3:0]  status,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  DA,
  output logic [4:0]  FS,
  output logic [63:0] k,
  output logic        selbork,
  output logic        Cin,
  output logic        W,
  output logic        triSelBtoD,
  output logic        triSelFtoD,
  output logic [3:0]  flags,
  output logic        busy,
  output logic        done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  localparam logic [2:0] OP_ALUR = 3'd1;
  localparam logic [2:0] OP_ALUI = 3'd2;
  localparam logic [2:0] OP_MOV  = 3'd3;
  localparam logic [2:0] OP_LOOP = 3'd4;

  typedef struct packed {
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic [4:0]  fs;
    logic [63:0] k;
    logic        selbork;
    logic        cin;
    logic        w;
    logic        tri_b;
    logic        tri_f;
  } ctrl_t;

  localparam ctrl_t IDLE_WORD = ctrl_t'(89'd0);

  logic [0:0]  state_r, state_nxt_s;
  logic [11:0] cnt_r, cnt_nxt_s;
  logic        capf_r, capf_nxt_s;
  ctrl_t       ctrl_r, ctrl_nxt_s;
  logic [3:0]  flags_r, flags_nxt_s;
  logic        ready_r, ready_nxt_s;
  logic        done_r, done_nxt_s;
  logic        busy_r;
  logic        accept_s;

  // Control word held for every EXEC cycle of a command.
  function automatic ctrl_t exec_word(input logic [2:0] op, input logic [4:0] fn,
                                      input logic [4:0] rd, input logic [4:0] rn,
                                      input logic [4:0] rm, input logic [11:0] imm,
                                      input logic cin);
    ctrl_t cw;
    cw = IDLE_WORD;
    case (op)
      OP_ALUR, OP_ALUI: begin
        cw.sa      = rn;
        cw.sb      = rm;
        cw.da      = rd;
        cw.fs      = fn;
        cw.cin     = cin;
        cw.w       = 1'b1;
        cw.tri_f   = 1'b1;
        cw.selbork = (op == OP_ALUI);
        cw.k       = (op == OP_ALUI) ? {52'd0, imm} : 64'd0;
      end
      OP_MOV: begin
        cw.sb    = rm;
        cw.da    = rd;
        cw.w     = 1'b1;
        cw.tri_b = 1'b1;
      end
      // rd is both source A and destination so the iteration accumulates into rd.
      OP_LOOP: begin
        cw.sa    = rd;
        cw.sb    = rn;
        cw.da    = rd;
        cw.fs    = fn;
        cw.cin   = cin;
        cw.w     = 1'b1;
        cw.tri_f = 1'b1;
      end
      default: cw = IDLE_WORD;
    endcase
    return cw;
  endfunction

  assign accept_s = cmd_valid & ready_r;

  // Next-state, next-output computation for the IDLE/EXEC sequencer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capf_nxt_s  = capf_r;
    ctrl_nxt_s  = ctrl_r;
    flags_nxt_s = flags_r;
    ready_nxt_s = ready_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ctrl_nxt_s  = IDLE_WORD;
        ready_nxt_s = 1'b1;
        capf_nxt_s  = 1'b0;
        cnt_nxt_s   = 12'd0;
        if (accept_s) begin
          case (cmd_op)
            OP_ALUR, OP_ALUI, OP_MOV, OP_LOOP: begin
              if ((cmd_op == OP_LOOP) && (cmd_imm == 12'd0)) begin
                done_nxt_s = 1'b1;
              end else begin
                state_nxt_s = ST_EXEC;
                cnt_nxt_s   = (cmd_op == OP_LOOP) ? cmd_imm : 12'd1;
                ctrl_nxt_s  = exec_word(cmd_op, cmd_fn, cmd_rd, cmd_rn, cmd_rm, cmd_imm, cmd_cin);
                ready_nxt_s = 1'b0;
                capf_nxt_s  = cmd_setf & (cmd_op != OP_MOV);
              end
            end
            default: done_nxt_s = 1'b1;
          endcase
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      ST_EXEC: begin
        if (capf_r) begin
          flags_nxt_s = status;
        end else begin
          flags_nxt_s = flags_r;
        end
        if (cnt_r <= 12'd1) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 12'd0;
          ctrl_nxt_s  = IDLE_WORD;
          ready_nxt_s = 1'b1;
          capf_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 12'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 12'd0;
        ctrl_nxt_s  = IDLE_WORD;
        ready_nxt_s = 1'b0;
        capf_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything and drops any in-flight command.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 12'd0;
      capf_r  <= 1'b0;
      ctrl_r  <= IDLE_WORD;
      flags_r <= 4'd0;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      capf_r  <= capf_nxt_s;
      ctrl_r  <= ctrl_nxt_s;
      flags_r <= flags_nxt_s;
      ready_r <= ready_nxt_s;
      done_r  <= done_nxt_s;
      busy_r  <= (state_nxt_s == ST_EXEC);
    end
  end

  assign cmd_ready  = ready_r;
  assign SA         = ctrl_r.sa;
  assign SB         = ctrl_r.sb;
  assign DA         = ctrl_r.da;
  assign FS         = ctrl_r.fs;
  assign k          = ctrl_r.k;
  assign selbork    = ctrl_r.selbork;
  assign Cin        = ctrl_r.cin;
  assign W          = ctrl_r.w;
  assign triSelBtoD = ctrl_r.tri_b;
  assign triSelFtoD = ctrl_r.tri_f;
  assign flags      = flags_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_datapath_controller.sv
// Scoreboard bench for datapath_controller: per-cycle expected control words are
// queued when a command is driven and compared one per clock by a monitor.
module tb_datapath_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_fn, cmd_rd, cmd_rn, cmd_rm;
  logic [11:0] cmd_imm;
  logic        cmd_cin, cmd_setf;
  logic [3:0]  status;
  logic [4:0]  SA, SB, DA, FS;
  logic [63:0] k;
  logic        selbork, Cin, W, triSelBtoD, triSelFtoD;
  logic [3:0]  flags;
  logic        busy, done;

  datapath_controller dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_fn(cmd_fn), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm(cmd_imm), .cmd_cin(cmd_cin), .cmd_setf(cmd_setf), .status(status),
    .SA(SA), .SB(SB), .DA(DA), .FS(FS), .k(k), .selbork(selbork), .Cin(Cin), .W(W),
    .triSelBtoD(triSelBtoD), .triSelFtoD(triSelFtoD), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [88:0] word;
    logic        ready;
    logic        busy;
    logic        done;
    logic        cap;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [3:0] exp_flags = 4'd0;
  logic       prev_cap = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [88:0] model_word(input logic [2:0] op, input logic [4:0] fn,
                                             input logic [4:0] rd, input logic [4:0] rn,
                                             input logic [4:0] rm, input logic [11:0] imm,
                                             input logic cin);
    case (op)
      3'd1:    return {rn, rm, rd, fn, 64'd0, 1'b0, cin, 1'b1, 1'b0, 1'b1};
      3'd2:    return {rn, rm, rd, fn, {52'd0, imm}, 1'b1, cin, 1'b1, 1'b0, 1'b1};
      3'd3:    return {5'd0, rm, rd, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      3'd4:    return {rd, rn, rd, fn, 64'd0, 1'b0, cin, 1'b1, 1'b0, 1'b1};
      default: return 89'd0;
    endcase
  endfunction

  function automatic logic [88:0] dut_word();
    return {SA, SB, DA, FS, k, selbork, Cin, W, triSelBtoD, triSelFtoD};
  endfunction

  task automatic send(input logic [2:0] op, input logic [4:0] fn, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [4:0] rm, input logic [11:0] imm,
                      input logic cin, input logic setf);
    int  n;
    bit  exec;
    exp_t e;
    @(negedge clock);
    for (int i = 0; i < 64 && sb_q.size() != 0; i++) @(negedge clock);
    if (sb_q.size() != 0) begin
      check_eq("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    cmd_op = op; cmd_fn = fn; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
    cmd_imm = imm; cmd_cin = cin; cmd_setf = setf; cmd_valid = 1'b1;
    exec = (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || ((op == 3'd4) && (imm != 12'd0));
    n = (op == 3'd4) ? int'(imm) : 1;
    if (exec) begin
      for (int i = 0; i < n; i++) begin
        e = '{word: model_word(op, fn, rd, rn, rm, imm, cin), ready: 1'b0, busy: 1'b1,
              done: 1'b0, cap: setf && (op != 3'd3)};
        sb_q.push_back(e);
      end
    end
    e = '{word: 89'd0, ready: 1'b1, busy: 1'b0, done: 1'b1, cap: 1'b0};
    sb_q.push_back(e);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  // Status changes only on the falling edge so it is stable around each capture edge.
  initial forever begin
    @(negedge clock);
    status = 4'($urandom);
  end

  // Per-cycle monitor: flags model, control word, handshake and tri-select invariant.
  initial forever begin
    exp_t e;
    @(posedge clock);
    #1;
    if (!reset) begin
      prev_cap = 1'b0;
    end else begin
      if (prev_cap) exp_flags = status;
      check_eq("flags", flags, exp_flags);
      if (sb_q.size() != 0) e = sb_q.pop_front();
      else e = '{word: 89'd0, ready: 1'b1, busy: 1'b0, done: 1'b0, cap: 1'b0};
      check_eq("word", dut_word(), e.word);
      check_eq("rdy_busy_done", {cmd_ready, busy, done}, {e.ready, e.busy, e.done});
      check_eq("tri_inv", {triSelBtoD & triSelFtoD, W & ~(triSelBtoD ^ triSelFtoD)}, 2'b00);
      prev_cap = e.cap;
    end
  end

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_word"}, dut_word(), 89'd0);
    check_eq({tag, "_flags_busy_done"}, {flags, busy, done}, 6'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_fn = 5'd0; cmd_rd = 5'd0;
    cmd_rn = 5'd0; cmd_rm = 5'd0; cmd_imm = 12'd0; cmd_cin = 1'b0; cmd_setf = 1'b0;
    status = 4'd0;
    #2 reset = 1'b0;
    #1 check_reset_state("reset0");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);

    send(3'd1, 5'h08, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1, 1'b1);      // ALUR setf
    send(3'd2, 5'h02, 5'd5, 5'd9, 5'd0, 12'hABC, 1'b0, 1'b0);    // ALUI setf=0
    send(3'd3, 5'h1F, 5'd4, 5'd8, 5'd7, 12'h123, 1'b1, 1'b1);    // MOV leaves flags
    send(3'd4, 5'h10, 5'd6, 5'd2, 5'd9, 12'd3, 1'b0, 1'b1);      // LOOP x3
    send(3'd4, 5'h04, 5'd6, 5'd2, 5'd9, 12'd0, 1'b1, 1'b1);      // LOOP imm=0
    send(3'd0, 5'h04, 5'd1, 5'd1, 5'd1, 12'd5, 1'b1, 1'b1);      // NOP
    send(3'd6, 5'h04, 5'd1, 5'd1, 5'd1, 12'd5, 1'b1, 1'b1);      // reserved
    send(3'd1, 5'h0C, 5'd31, 5'd31, 5'd30, 12'd0, 1'b0, 1'b0);   // ALUR setf=0, r31
    for (int i = 0; i < 6; i++) begin
      send(3'($urandom_range(1, 4)), 5'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 12'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
    end

    // Reset in the second iteration of a long LOOP: no done, outputs cleared at once.
    send(3'd4, 5'h08, 5'd6, 5'd2, 5'd0, 12'd10, 1'b1, 1'b1);
    @(posedge clock);
    #3 reset = 1'b0;
    sb_q.delete();
    exp_flags = 4'd0;
    #1 check_reset_state("reset_loop");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    send(3'd1, 5'h18, 5'd7, 5'd3, 5'd4, 12'd0, 1'b1, 1'b1);

    @(negedge clock);
    for (int i = 0; i < 64 && sb_q.size() != 0; i++) @(negedge clock);
    check_eq("final_drain", sb_q.size(), 0);
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/datapath_controller.md
# datapath_controller

Command sequencer that generates the per-cycle control word for the LEGv8 datapath: register selects, ALU function, constant/B mux select, write enable and D-bus drive enables. It accepts one command at a time over a valid/ready handshake and issues one or more execute cycles. It captures ALU status flags and signals completion. It is the producer end of the datapath control interface.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept; high only in IDLE
- cmd_op  in  3  000 NOP, 001 ALUR, 010 ALUI, 011 MOV, 100 LOOP; 101–111 reserved (treated as NOP)
- cmd_fn  in  5  ALU function code, passed unmodified to FS
- cmd_rd, cmd_rn, cmd_rm  in  5 each  destination / first / second register
- cmd_imm  in  12  immediate (ALUI) or iteration count (LOOP)
- cmd_cin  in  1  carry-in for ALU ops
- cmd_setf  in  1  update flags from this command
- status  in  4  ALU status from datapath
- SA, SB, DA, FS  out  5 each  datapath control fields
- k  out  64  constant to datapath
- selbork  out  1  1 = k, 0 = B into ALU
- Cin  out  1  ALU carry-in
- W  out  1  register-file write enable
- triSelBtoD, triSelFtoD  out  1 each  D-bus drive enables
- flags  out  4  last captured status
- busy  out  1  not in IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, EXEC. All outputs are registered.
- IDLE: cmd_ready=1. The controller drives the idle control word: every control output is 0, including W, both tri-selects, k and FS. On cmd_valid&&cmd_ready it latches all cmd_* fields.
  - NOP/reserved: stays IDLE, pulses done next cycle.
  - LOOP with imm=0: stays IDLE, pulses done next cycle.
  - Every other op: goes to EXEC.
- EXEC control word, by op:
  - ALUR: SA=rn, SB=rm, DA=rd, FS=fn, Cin=cin, selbork=0, W=1, triSelFtoD=1.
  - ALUI: same as ALUR except selbork=1, k={52'b0,imm}.
  - MOV: SB=rm, DA=rd, W=1, triSelBtoD=1, triSelFtoD=0, FS=0, selbork=0. This copies rm to rd via the D bus.
  - LOOP: SA=rd, SB=rn, DA=rd, FS=fn, Cin=cin, selbork=0, W=1, triSelFtoD=1. Repeated imm times, so rd ← rd FS rn iterated.
- Counter: 12-bit, loaded with imm (LOOP) or 1 (ALUR/ALUI/MOV), decremented per EXEC cycle. When the count reaches 0, return to IDLE and pulse done.
- Flags: at the end of each EXEC cycle of ALUR/ALUI/LOOP with setf=1, flags ← status. LOOP therefore holds the final iteration's status. MOV, NOP and setf=0 leave flags unchanged.
- Invariant: triSelBtoD and triSelFtoD are never both 1. W=1 only together with exactly one tri-select.
- Register 31 gets no special handling.
- Reset asserted (any time, including mid-LOOP): state=IDLE, all outputs 0 immediately, flags=0, counter=0. The in-flight command is dropped with no done.

## Timing
- Command accepted at edge t. EXEC cycles are t+1 … t+N (N=1 for single ops, N=imm for LOOP).
- The datapath writes rd at the end of each EXEC cycle.
- done=1 and cmd_ready=1 in cycle t+N+1. A new command may be accepted at that same edge.
- NOP / LOOP imm=0: done in cycle t+1, and cmd_ready stays 1.
- Throughput: one single-cycle op every 2 cycles.
- busy = (state==EXEC).

## Test plan
- Reset: reset=0 asynchronously mid-cycle → every control output, flags, done, busy = 0 immediately. After release, cmd_ready=1.
- ALUR rd=3 rn=1 rm=2 fn=5'h08 cin=1 setf=1 → one cycle with SA=1, SB=2, DA=3, FS=8, Cin=1, W=1, triSelFtoD=1, selbork=0. flags=status sampled that cycle. done the next cycle. Idle word otherwise.
- ALUI imm=12'hABC rd=5 → k=64'h0000_0000_0000_0ABC, selbork=1, W=1 for one cycle. With setf=0, flags unchanged.
- MOV rd=4 rm=7 → one cycle with SB=7, DA=4, W=1, triSelBtoD=1, triSelFtoD=0. flags unchanged. Checker asserts that both tri-selects are never 1 together in any test.
- LOOP rd=6 rn=2 imm=3 setf=1 → exactly 3 EXEC cycles with SA=DA=6, SB=2, W=1. cmd_ready low for 3 cycles. flags=third-cycle status. done in the 4th cycle. LOOP imm=0 → W never asserted, done next cycle.
- Reset during LOOP imm=10 at iteration 2 → W drops the same cycle, no done. After release, a fresh ALUR is accepted and executes normally.
